// File: rtl/pwm_capture.sv
// Purpose: measures period and high time of an asynchronous PWM input in clk cycles.
// Latency: valid pulses SYNC_STAGES cycles after pwm_in is first sampled high at a rising edge.
// Backpressure: none; valid is a single-cycle strobe and results hold until the next update.
module pwm_capture #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             valid,
    output logic             overflow,
    output logic             level
);

    localparam logic [CNT_W-1:0] MAXV = '1;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               prev_q;
    logic               s_last;
    logic               rise;
    logic [CNT_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]   hc_q, hc_d;
    logic [CNT_W-1:0]   period_d, high_d;
    logic               valid_d, overflow_d;

    assign s_last = sync_q[SYNC_STAGES-1];
    assign rise   = s_last & ~prev_q;
    assign level  = s_last;

    // Synchronizer chain and edge-detect history; runs regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q <= s_last;
        end
    end

    // State, counters and published results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            hc_q       <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hc_q       <= hc_d;
            period_cnt <= period_d;
            high_cnt   <= high_d;
            valid      <= valid_d;
            overflow   <= overflow_d;
        end
    end

    // Next-state logic: a rise closes the current window and opens a new one;
    // a window reaching MAXV without a rise parks in TIMEOUT with overflow set.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hc_d       = hc_q;
        period_d   = period_cnt;
        high_d     = high_cnt;
        valid_d    = 1'b0;
        overflow_d = overflow;

        if (!en) begin
            // Disabled: drop any partial window; published results are kept.
            state_d = IDLE;
            pc_d    = '0;
            hc_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        pc_d    = ONE;
                        hc_d    = ONE;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // Rise takes priority over the MAXV check, so MAXV is reportable.
                        period_d   = pc_q;
                        high_d     = hc_q;
                        valid_d    = 1'b1;
                        overflow_d = 1'b0;
                        pc_d       = ONE;
                        hc_d       = ONE;
                    end else if (pc_q == MAXV) begin
                        overflow_d = 1'b1;
                        state_d    = TIMEOUT;
                    end else begin
                        pc_d = pc_q + ONE;
                        hc_d = hc_q + {{(CNT_W-1){1'b0}}, s_last};
                    end
                end
                TIMEOUT: begin
                    // Counters frozen; the next rise only re-arms, overflow clears at the next valid.
                    if (rise) begin
                        pc_d    = ONE;
                        hc_d    = ONE;
                        state_d = MEASURE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM signal generator.
- Samples an external PWM waveform and measures its period and high time in clk cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Used for loopback self-test of the generator and for reading external PWM sources.

Parameters:
CNT_W, 8, width of the period and high-time counters and outputs; MAXV = 2^CNT_W - 1
SYNC_STAGES, 2, number of synchronizer flops on pwm_in (minimum 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  measurement enable
pwm_in  input  1  asynchronous PWM input
period_cnt  output  CNT_W  last measured period in clk cycles
high_cnt  output  CNT_W  last measured high time in clk cycles
valid  output  1  one-cycle strobe: period_cnt/high_cnt just updated
overflow  output  1  period exceeded MAXV since the last valid
level  output  1  synchronized pwm_in (last synchronizer stage)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. No other clock or reset domains.
- Reset: all registers go to 0 immediately, without a clock edge. This covers synchronizer, prev, counters, outputs and state (= IDLE).
  - period_cnt = 0, high_cnt = 0, valid = 0, overflow = 0, level = 0.
  - Reset mid-measurement discards the partial window.
- Synchronizer: chain s[0..SYNC_STAGES-1] with s[0] <= pwm_in. It always runs, regardless of en. level = s[last].
- Edge detect: prev <= s[last]. rise = s[last] & ~prev (combinational).
- Internal counters pc, hc (CNT_W bits).
- FSM states: IDLE, MEASURE, TIMEOUT.
  - IDLE: wait for rise. On rise: pc <= 1, hc <= 1, go to MEASURE. No valid.
  - MEASURE, rise: period_cnt <= pc, high_cnt <= hc, valid <= 1, overflow <= 0, pc <= 1, hc <= 1. Stay in MEASURE.
  - MEASURE, no rise and pc == MAXV: overflow <= 1, go to TIMEOUT. Outputs hold, no valid.
  - MEASURE, otherwise: pc <= pc + 1; hc <= hc + s[last].
  - TIMEOUT: counters frozen, overflow held at 1. On rise: pc <= 1, hc <= 1, go to MEASURE, no valid. overflow clears at the next valid.
- Simultaneous rise and pc == MAXV: rise wins, giving a valid measurement with period_cnt = MAXV.
- Resulting range: period MAXV is reported normally; period MAXV+1 or longer sets overflow. hc <= pc always, so hc never overflows.
- valid is high for exactly one cycle per rise in MEASURE. It is 0 in every other cycle.
- Latency: if pwm_in is first sampled high at edge k, valid is high after edge k+SYNC_STAGES.
- en = 0 (synchronous):
  - State is forced to IDLE, pc and hc cleared, valid = 0.
  - period_cnt, high_cnt and overflow hold.
  - After re-enable, the first rise only arms the block; the second rise produces the first valid.
- 0% or 100% duty: no rises, so TIMEOUT is reached after MAXV cycles. Software reads level to tell which.
- Glitches shorter than one clk may be missed. This is acceptable; no filtering.

Test Plan:
(All scenarios use CNT_W = 8 and SYNC_STAGES = 2.)
- Basic measurement: reset, en = 1, pwm_in repeating 3 cycles high / 5 low (clk-aligned). First rise gives no valid. Each later rise gives valid with period_cnt = 8, high_cnt = 3, overflow = 0, and valid is a single cycle.
- Latency: drive pwm_in high at edge k of the second period. valid = 1 after edge k+2 and 0 after edge k+3.
- Boundary: period 255 (100 high) gives valid with period_cnt = 255, high_cnt = 100, overflow = 0. Period 256 gives overflow = 1 with no valid, and outputs keep their previous values.
- Stuck input: after a good measurement, hold pwm_in low. overflow = 1 within 255 cycles of the last rise, level = 0. Restart the 3/5 waveform: first rise gives no valid; second rise gives valid with 8/3 and overflow back to 0.
- Enable: drop en mid-window for 10 cycles. No valid during or after the drop until two rises after re-enable. period_cnt and high_cnt hold their old values throughout.
- Async reset: assert rst between clk edges mid-measurement. All outputs are 0 before the next clk edge. After release, the first rise gives no valid.
